// File: rtl/adc_sum_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sum_sched_pkg
// Shared types and constants for the ADC-sum register scheduler.
//   sched_state_t : scheduler FSM states (IDLE, LOAD, HOLD)
//   TAG_W         : width of the published {chan, seq} tag word
//   CHAN_W/SEQ_W  : field widths inside the tag
//   TSTAMP_W      : width of the optional publish timestamp
//   idx_width()   : index width for a count, never less than one bit
// ---------------------------------------------------------------------------
package adc_sum_sched_pkg;

    localparam int TAG_W    = 16;
    localparam int CHAN_W   = 8;
    localparam int SEQ_W    = 8;
    localparam int TSTAMP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    // Width needed to index n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sum_rr_pick.sv
// ---------------------------------------------------------------------------
// adc_sum_rr_pick
// Combinational round-robin picker. Returns the first pending channel
// strictly after last_grant, wrapping back to channel 0.
// Ports:
//   pending    in  N_CH   per-channel request bits
//   last_grant in  IDX_W  most recently served channel
//   grant      out IDX_W  chosen channel (0 when nothing is pending)
//   any        out 1      at least one channel is pending
// ---------------------------------------------------------------------------
module adc_sum_rr_pick #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    // Two descending scans: the second only considers channels above
    // last_grant, so any hit there overrides a wrapped hit from the first,
    // and within each scan the lowest index is assigned last and wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pending[c] && (IDX_W'(c) <= last_grant)) begin
                grant = IDX_W'(c);
                any   = 1'b1;
            end
        end
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pending[c] && (IDX_W'(c) > last_grant)) begin
                grant = IDX_W'(c);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sum_reg_sched.sv
// ---------------------------------------------------------------------------
// adc_sum_reg_sched
// Shares one software register between N_CH ADC-sum producers. Each
// producer's sum is latched on its valid strobe; the scheduler publishes
// one channel at a time in round-robin order and holds the word for DWELL
// cycles so the register's clock-domain capture sees a settled value. A
// companion tag {chan, seq} lets software identify the channel and spot
// new data.
//
// Optional feature: define ADC_SUM_SCHED_TSTAMP_EN to add reg_tstamp, a
// free-running user_clk count sampled when reg_data is updated.
//
// Ports:
//   user_clk    in   1        sole clock
//   user_rst_n  in   1        asynchronous active-low reset
//   en          in   1        allow new publishes
//   sum_in      in   N_CH*DW  channel c at [c*DW +: DW]
//   sum_vld     in   N_CH     1-cycle strobe, sum_in slice valid
//   reg_data    out  DW       published sum
//   reg_tag     out  16       {chan[7:0], seq[7:0]}
//   reg_upd     out  1        pulse: reg_data/reg_tag changed this cycle
//   drop_cnt    out  CNT_W    saturating count of overwritten sums
//   reg_tstamp  out  32       (ADC_SUM_SCHED_TSTAMP_EN only) publish time
//   busy        out  1        FSM not in IDLE
// ---------------------------------------------------------------------------
module adc_sum_reg_sched
    import adc_sum_sched_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DW    = 32,
    parameter int DWELL = 64,
    parameter int CNT_W = 16
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    input  logic                en,
    input  logic [N_CH*DW-1:0]  sum_in,
    input  logic [N_CH-1:0]     sum_vld,
    output logic [DW-1:0]       reg_data,
    output logic [TAG_W-1:0]    reg_tag,
    output logic                reg_upd,
    output logic [CNT_W-1:0]    drop_cnt,
`ifdef ADC_SUM_SCHED_TSTAMP_EN
    output logic [TSTAMP_W-1:0] reg_tstamp,
`endif
    output logic                busy
);

    localparam int IDX_W   = idx_width(N_CH);
    localparam int DWELL_W = idx_width(DWELL);
    localparam int DROP_W  = idx_width(N_CH + 1);
    localparam int SUM_W   = CNT_W + DROP_W;

    localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(N_CH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
    localparam logic [SUM_W-1:0]   CNT_MAX    = SUM_W'({CNT_W{1'b1}});

    sched_state_t        state_q;
    sched_state_t        state_d;

    logic [DW-1:0]       sum_buf [N_CH];
    logic [N_CH-1:0]     pending_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    grant_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [SEQ_W-1:0]    seq_q;

    logic [IDX_W-1:0]    pick_grant;
    logic                pick_any;
    logic                start_now;
    logic                load_now;
    logic [N_CH-1:0]     clr_mask;
    logic [N_CH-1:0]     drop_mask;
    logic [DROP_W-1:0]   drop_inc;
    logic [SUM_W-1:0]    drop_sum;
    logic [CNT_W-1:0]    drop_next;

    adc_sum_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    assign start_now = (state_q == IDLE) && en && pick_any;
    assign load_now  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);

    // The channel being published loses its pending bit on the LOAD edge.
    always_comb begin
        clr_mask = '0;
        if (load_now) begin
            clr_mask[grant_q] = 1'b1;
        end
    end

    // A strobe on a channel still waiting to publish overwrites an unseen
    // sum. A strobe racing the clear of its own channel is not a drop: the
    // old word is published and the new one stays pending.
    assign drop_mask = sum_vld & pending_q & ~clr_mask;

    always_comb begin
        drop_inc = '0;
        for (int c = 0; c < N_CH; c++) begin
            drop_inc = drop_inc + DROP_W'(drop_mask[c]);
        end
    end

    // Widened add so several drops in one edge saturate cleanly.
    assign drop_sum  = SUM_W'(drop_cnt) + SUM_W'(drop_inc);
    assign drop_next = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

    // Capture path runs regardless of en or FSM state; set beats clear.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            pending_q <= '0;
            drop_cnt  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sum_buf[c] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~clr_mask) | sum_vld;
            drop_cnt  <= drop_next;
            for (int c = 0; c < N_CH; c++) begin
                if (sum_vld[c]) begin
                    sum_buf[c] <= sum_in[c*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD runs to completion even if en drops; en only gates new starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_now) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (dwell_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output registers only move on the LOAD->HOLD edge, so the software
    // register always samples a registered, settled word.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            dwell_q      <= '0;
            seq_q        <= '0;
            reg_data     <= '0;
            reg_tag      <= '0;
            reg_upd      <= 1'b0;
        end else begin
            reg_upd <= load_now;
            if (start_now) begin
                grant_q <= pick_grant;
            end
            if (load_now) begin
                reg_data     <= sum_buf[grant_q];
                reg_tag      <= {CHAN_W'(grant_q), seq_q};
                seq_q        <= seq_q + SEQ_W'(1);
                last_grant_q <= grant_q;
                dwell_q      <= DWELL_LOAD;
            end else if ((state_q == HOLD) && (dwell_q != '0)) begin
                dwell_q <= dwell_q - DWELL_W'(1);
            end
        end
    end

`ifdef ADC_SUM_SCHED_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp_q;

    // Free-running time base; sampled alongside reg_data.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            tstamp_q   <= '0;
            reg_tstamp <= '0;
        end else begin
            tstamp_q <= tstamp_q + TSTAMP_W'(1);
            if (load_now) begin
                reg_tstamp <= tstamp_q;
            end
        end
    end
`endif

endmodule
